// File: rtl/single_pin_bus_ctrl.sv
`timescale 1ns/1ps
// single_pin_bus_ctrl
//
// Shares one bidirectional pin (through an IOBUF) between two requesters.
// Each requester asks for the pin with a level request. The winner drives a
// single bit for HOLD_CYC cycles. The pin is then released for a turnaround
// period of TURN_CYC cycles before anyone may drive it again. An external
// force_release cuts a drive short. While the pin is released and idle, the
// block watches the pin for level changes and counts them.
//
// Parameters
//   HOLD_CYC      cycles a granted bit is driven onto the pin (1-255)
//   TURN_CYC      minimum released cycles between drive ownerships (1-255)
//
// Ports
//   clk_100MHz    system clock, rising edge
//   rst_n         asynchronous active-low reset
//   req[1:0]      per-requester drive request, held until gnt
//   dat[1:0]      per-requester bit to drive, sampled in the IDLE cycle
//   force_release 1 = the pin must be released
//   pin_o         pin level returned by the IOBUF
//   pin_i         value driven to the IOBUF I input
//   pin_t         IOBUF T input, 1 = released (tri-state), 0 = driving
//   gnt[1:0]      one-cycle grant pulse, first DRIVE cycle
//   done[1:0]     one-cycle completion pulse, first TURN cycle after a full drive
//   aborted       one-cycle pulse when force_release cut a drive short
//   rx_level      pin_o after a 2-flop synchronizer
//   rx_edge       one-cycle pulse when rx_level changes while IDLE
//   rx_edge_cnt   running count of rx_edge pulses, wraps 255 -> 0
module single_pin_bus_ctrl #(
    parameter int HOLD_CYC = 8,
    parameter int TURN_CYC = 4
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] dat,
    input  logic       force_release,
    input  logic       pin_o,
    output logic       pin_i,
    output logic       pin_t,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       aborted,
    output logic       rx_level,
    output logic       rx_edge,
    output logic [7:0] rx_edge_cnt
);

    typedef enum logic [1:0] {
        TURN  = 2'd0,
        IDLE  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [7:0] TURN_LAST = 8'(TURN_CYC - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       last;
    logic       last_nxt;
    logic       owner;
    logic       owner_nxt;
    logic       winner;
    logic       pin_i_nxt;
    logic       pin_t_nxt;
    logic [1:0] gnt_nxt;
    logic [1:0] done_nxt;
    logic       aborted_nxt;
    logic       rx_sync_p0;
    logic       rx_change;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        winner = ~last;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~last;
        endcase
    end

    // Next state and next (registered) outputs. The defaults describe a
    // released pin with no pulses; each state overrides only what it needs.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 8'd1;
        last_nxt    = last;
        owner_nxt   = owner;
        pin_t_nxt   = 1'b1;
        pin_i_nxt   = 1'b0;
        gnt_nxt     = 2'b00;
        done_nxt    = 2'b00;
        aborted_nxt = 1'b0;

        case (state)
            TURN: begin
                // force_release does not stall the turnaround count.
                if (cnt == TURN_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            end

            IDLE: begin
                cnt_nxt = 8'd0;
                if ((|req) && !force_release) begin
                    state_nxt = DRIVE;
                    owner_nxt = winner;
                    last_nxt  = winner;
                    gnt_nxt   = winner ? 2'b10 : 2'b01;
                    pin_t_nxt = 1'b0;
                    pin_i_nxt = dat[winner];
                end
            end

            DRIVE: begin
                if (force_release) begin
                    // Abort: no done pulse. The pointer was already
                    // updated at grant time.
                    state_nxt   = TURN;
                    cnt_nxt     = 8'd0;
                    aborted_nxt = 1'b1;
                end else if (cnt == HOLD_LAST) begin
                    state_nxt = TURN;
                    cnt_nxt   = 8'd0;
                    done_nxt  = owner ? 2'b10 : 2'b01;
                end else begin
                    // Hold the bit captured at grant; req/dat are ignored.
                    pin_t_nxt = 1'b0;
                    pin_i_nxt = pin_i;
                end
            end

            default: begin
                state_nxt = TURN;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TURN;
            cnt     <= 8'd0;
            last    <= 1'b1;
            owner   <= 1'b0;
            pin_t   <= 1'b1;
            pin_i   <= 1'b0;
            gnt     <= 2'b00;
            done    <= 2'b00;
            aborted <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            owner   <= owner_nxt;
            pin_t   <= pin_t_nxt;
            pin_i   <= pin_i_nxt;
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            aborted <= aborted_nxt;
        end
    end

    // rx_level is about to take the synchronized value. An edge is only
    // reported while IDLE. Changes that arise while driving or in
    // turnaround are usually the block's own drive, so they are ignored.
    assign rx_change = (state == IDLE) && (rx_sync_p0 != rx_level);

    // Synchronizer stage p0 -> rx_level
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_p0  <= 1'b0;
            rx_level    <= 1'b0;
            rx_edge     <= 1'b0;
            rx_edge_cnt <= 8'd0;
        end else begin
            rx_sync_p0 <= pin_o;
            rx_level   <= rx_sync_p0;
            rx_edge    <= rx_change;
            if (rx_change) begin
                rx_edge_cnt <= rx_edge_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/single_pin_bus_ctrl.md
SINGLE_PIN_BUS_CTRL -- requirements
Module: single_pin_bus_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL clear on rst_n low regardless of clk_100MHz.
REQ-002 The block SHALL have parameter HOLD_CYC, default 8, meaning cycles a granted bit is driven onto the pin (legal 1-255).
REQ-003 The block SHALL have parameter TURN_CYC, default 4, meaning minimum released cycles between drive ownerships (legal 1-255).
REQ-004 clk_100MHz  in  1  system clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  2  per-requester drive request, level, held until gnt.
REQ-007 dat  in  2  per-requester bit value to drive, sampled at grant.
REQ-008 force_release  in  1  external override, 1 = pin must be released.
REQ-009 pin_o  in  1  pin level from IOBUF O.
REQ-010 pin_i  out  1  drive value to IOBUF I.
REQ-011 pin_t  out  1  IOBUF T, 1 = tri-state (released), 0 = driving.
REQ-012 gnt  out  2  one-cycle grant pulse per requester.
REQ-013 done  out  2  one-cycle completion pulse per requester.
REQ-014 aborted  out  1  one-cycle pulse, drive cut short by force_release.
REQ-015 rx_level  out  1  pin_o after 2-flop synchronizer.
REQ-016 rx_edge  out  1  one-cycle pulse on rx_level change while released.
REQ-017 rx_edge_cnt  out  8  count of rx_edge pulses, wraps 255->0.

Function
REQ-018 FSM states SHALL be TURN, IDLE, DRIVE; all outputs registered.
REQ-019 TURN: pin_t=1; turnaround counter counts TURN_CYC cycles, then IDLE.
REQ-020 IDLE: pin_t=1; if any req and force_release=0, next cycle enters DRIVE.
REQ-021 Arbitration SHALL be round-robin: single requester wins; on tie, the requester not served last wins; last-served pointer resets to 1 (req[0] wins first tie).
REQ-022 First DRIVE cycle: pin_t=0, pin_i=dat of winner latched on the IDLE cycle, gnt[winner]=1 for that cycle only.
REQ-023 DRIVE SHALL last exactly HOLD_CYC cycles with pin_i constant, then TURN; done[winner]=1 in first TURN cycle.
REQ-024 req/dat changes during DRIVE or TURN SHALL have no effect on the current drive.
REQ-025 force_release=1 in DRIVE: next cycle pin_t=1, state TURN (full TURN_CYC), aborted=1 one cycle, no done pulse, last-served pointer still updated.
REQ-026 force_release=1 in IDLE or TURN: no grant issued; TURN counting continues; IDLE held until force_release=0.
REQ-027 Two drives SHALL never be separated by fewer than TURN_CYC released cycles.
REQ-028 rx_edge SHALL pulse only when state is IDLE and rx_level differs from its prior value; edges in DRIVE or TURN are ignored.
REQ-029 rx_edge_cnt SHALL increment by 1 per rx_edge, modulo 256.
REQ-030 gnt, done, aborted SHALL be one-hot-or-zero; gnt and done never for both requesters same cycle.

Reset
REQ-031 Under rst_n=0: state TURN with counter cleared, pin_t=1, pin_i=0, gnt=0, done=0, aborted=0, rx_level=0, rx_edge=0, rx_edge_cnt=0, pointer=1.
REQ-032 After rst_n release, pin SHALL stay released at least TURN_CYC cycles before any grant.
REQ-033 Reset asserted mid-DRIVE SHALL release pin (pin_t=1) asynchronously, with no done or aborted pulse.

Verification
REQ-034 Reset release, req=01, dat=01 -> pin_t=1 for 4 cycles + IDLE cycle, gnt[0] one cycle, pin_t=0/pin_i=1 for 8 cycles, done[0] next cycle.
REQ-035 req=11 held -> grants alternate 0,1,0,...; gaps between drives >= 4 released cycles.
REQ-036 force_release pulsed at DRIVE cycle 3 -> pin_t=1 next cycle, aborted=1, no done, next grant >= 4 cycles later.
REQ-037 pin_o toggled 3 times while IDLE, 2 times during DRIVE -> rx_edge_cnt=3 (after 2-cycle sync delay).
REQ-038 rst_n low during DRIVE -> pin_t=1 immediately, all pulses 0; recovery repeats REQ-034 timing.
REQ-039 256 rx_edges from 0 -> rx_edge_cnt=0.
